ahb_lite_cmd_bridge: RTL and testbench



---
 rtl/ahb_lite_cmd_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_ahb_lite_cmd_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_cmd_bridge.sv
// AHB-Lite slave front end for the SDRAM path: turns each accepted transfer into one
// command FIFO word and, for reads, returns the matching response FIFO word on HRDATA.
module ahb_lite_cmd_bridge #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_WIDTH  = 1 + 2 + ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  CMD_WEN,
    output logic [CMD_WIDTH-1:0]  CMD_WDATA,
    input  logic                  CMD_WFULL,
    output logic                  RSP_REN,
    input  logic [DATA_WIDTH-1:0] RSP_RDATA,
    input  logic                  RSP_REMPTY
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_CMD  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_ERR1    = 3'd5,
        ST_ERR2    = 3'd6
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    state_t                accept_state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  write_r;
    logic [1:0]            size_r;
    logic [DATA_WIDTH-1:0] hrdata_r;
    logic                  accept_s;
    logic                  take_s;
    logic                  size_err_s;
    logic                  hreadyout_s;
    logic                  hresp_s;
    logic                  cmd_wen_s;
    logic                  rsp_ren_s;
    logic                  unused_s;

    // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
    assign unused_s   = HTRANS[0];
    assign accept_s   = HSEL & HREADY & HTRANS[1];
    assign size_err_s = (HSIZE > 3'd2);

    // Destination of a newly accepted address phase from any state that can take one.
    always_comb begin
        accept_state_s = ST_IDLE;
        if (!accept_s) begin
            accept_state_s = ST_IDLE;
        end else if (size_err_s) begin
            accept_state_s = ST_ERR1;
        end else if (HWRITE) begin
            accept_state_s = ST_WR;
        end else begin
            accept_state_s = ST_RD_CMD;
        end
    end

    // Address phases are only captured where the bus is actually ready for them;
    // ERR2 deliberately drops a pending accept (AHB error cancel).
    always_comb begin
        take_s = 1'b0;
        case (state_r)
            ST_IDLE:    take_s = accept_s;
            ST_WR:      take_s = accept_s & ~CMD_WFULL;
            ST_RD_DATA: take_s = accept_s;
            default:    take_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_next_s = accept_state_s;
            end
            ST_WR: begin
                if (!CMD_WFULL) begin
                    state_next_s = accept_state_s;
                end else begin
                    state_next_s = ST_WR;
                end
            end
            ST_RD_CMD: begin
                if (!CMD_WFULL) begin
                    state_next_s = ST_RD_WAIT;
                end else begin
                    state_next_s = ST_RD_CMD;
                end
            end
            ST_RD_WAIT: begin
                if (!RSP_REMPTY) begin
                    state_next_s = ST_RD_DATA;
                end else begin
                    state_next_s = ST_RD_WAIT;
                end
            end
            ST_RD_DATA: begin
                state_next_s = accept_state_s;
            end
            ST_ERR1: begin
                state_next_s = ST_ERR2;
            end
            ST_ERR2: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode; push/pop strobes track FIFO flags combinationally so a write
    // completes with zero wait states.
    always_comb begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b0;
        cmd_wen_s   = 1'b0;
        rsp_ren_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                hreadyout_s = 1'b1;
            end
            ST_WR: begin
                hreadyout_s = ~CMD_WFULL;
                cmd_wen_s   = ~CMD_WFULL;
            end
            ST_RD_CMD: begin
                hreadyout_s = 1'b0;
                cmd_wen_s   = ~CMD_WFULL;
            end
            ST_RD_WAIT: begin
                hreadyout_s = 1'b0;
                rsp_ren_s   = ~RSP_REMPTY;
            end
            ST_RD_DATA: begin
                hreadyout_s = 1'b1;
            end
            ST_ERR1: begin
                hreadyout_s = 1'b0;
                hresp_s     = 1'b1;
            end
            ST_ERR2: begin
                hreadyout_s = 1'b1;
                hresp_s     = 1'b1;
            end
            default: begin
                hreadyout_s = 1'b1;
            end
        endcase
    end

    // Address/control capture for the transfer entering its data phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            write_r <= 1'b0;
            size_r  <= 2'b00;
        end else if (take_s) begin
            addr_r  <= HADDR;
            write_r <= HWRITE;
            size_r  <= HSIZE[1:0];
        end
    end

    // Holds the last returned read word so HRDATA stays stable outside RD_DATA.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hrdata_r <= {DATA_WIDTH{1'b0}};
        end else if (state_r == ST_RD_DATA) begin
            hrdata_r <= RSP_RDATA;
        end
    end

    assign HREADYOUT = hreadyout_s;
    assign HRESP     = hresp_s;
    assign CMD_WEN   = cmd_wen_s;
    assign RSP_REN   = rsp_ren_s;
    assign HRDATA    = (state_r == ST_RD_DATA) ? RSP_RDATA : hrdata_r;
    assign CMD_WDATA = {write_r, size_r, addr_r, (write_r ? HWDATA : {DATA_WIDTH{1'b0}})};

endmodule

// File: tb/tb_ahb_lite_cmd_bridge.sv
// Directed bench for ahb_lite_cmd_bridge: single slave, HREADY looped back from HREADYOUT.
module tb_ahb_lite_cmd_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [24:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        CMD_WEN;
    logic [59:0] CMD_WDATA;
    logic        CMD_WFULL;
    logic        RSP_REN;
    logic [31:0] RSP_RDATA;
    logic        RSP_REMPTY;

    int total = 0;
    int bad   = 0;

    assign HREADY = HREADYOUT;

    ahb_lite_cmd_bridge dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .CMD_WEN(CMD_WEN),
        .CMD_WDATA(CMD_WDATA), .CMD_WFULL(CMD_WFULL), .RSP_REN(RSP_REN),
        .RSP_RDATA(RSP_RDATA), .RSP_REMPTY(RSP_REMPTY)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to 2 time units after the next rising edge
    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic addr_ph(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                           input logic [24:0] addr);
        HSEL = 1'b1; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
    endtask

    function automatic logic [63:0] cw(input logic w, input logic [1:0] s,
                                       input logic [24:0] a, input logic [31:0] d);
        return {4'h0, w, s, a, d};
    endfunction

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = 25'h0; HWRITE = 1'b0; HTRANS = 2'b00;
        HSIZE = 3'd0; HWDATA = 32'h0; CMD_WFULL = 1'b0; RSP_RDATA = 32'h0; RSP_REMPTY = 1'b1;
        #3;
        chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("rst_hresp",     64'(HRESP),     64'd0);
        chk("rst_cmd_wen",   64'(CMD_WEN),   64'd0);
        chk("rst_rsp_ren",   64'(RSP_REN),   64'd0);
        chk("rst_hrdata",    64'(HRDATA),    64'd0);
        tick();
        HRESET = 1'b0;
        tick();

        // single write
        addr_ph(2'b10, 1'b1, 3'd2, 25'h100);
        #1 chk("w1_addr_ready", 64'(HREADYOUT), 64'd1);
        chk("w1_addr_nowen", 64'(CMD_WEN), 64'd0);
        tick();
        HTRANS = 2'b00; HWDATA = 32'hDEADBEEF;
        #1 chk("w1_wen", 64'(CMD_WEN), 64'd1);
        chk("w1_word",  64'(CMD_WDATA), cw(1'b1, 2'b10, 25'h100, 32'hDEADBEEF));
        chk("w1_ready", 64'(HREADYOUT), 64'd1);
        tick();
        #1 chk("w1_after_wen", 64'(CMD_WEN), 64'd0);

        // write stalled by a full command FIFO for 3 cycles
        addr_ph(2'b10, 1'b1, 3'd1, 25'h0ABCDE);
        tick();
        HTRANS = 2'b00; HWDATA = 32'hCAFEF00D; CMD_WFULL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("w2_stall%0d_ready", i), 64'(HREADYOUT), 64'd0);
            chk($sformatf("w2_stall%0d_wen", i), 64'(CMD_WEN), 64'd0);
            tick();
        end
        CMD_WFULL = 1'b0;
        #1 chk("w2_wen", 64'(CMD_WEN), 64'd1);
        chk("w2_ready", 64'(HREADYOUT), 64'd1);
        chk("w2_word",  64'(CMD_WDATA), cw(1'b1, 2'b01, 25'h0ABCDE, 32'hCAFEF00D));
        tick();
        #1 chk("w2_after_wen", 64'(CMD_WEN), 64'd0);

        // read with the response arriving 5 cycles after the command push
        addr_ph(2'b10, 1'b0, 3'd2, 25'h1234);
        HWDATA = 32'hFFFFFFFF;
        tick();
        HTRANS = 2'b00;
        #1 chk("r1_cmd_wen",   64'(CMD_WEN),   64'd1);
        chk("r1_cmd_word",     64'(CMD_WDATA), cw(1'b0, 2'b10, 25'h1234, 32'h0));
        chk("r1_cmd_ready",    64'(HREADYOUT), 64'd0);
        chk("r1_cmd_ren",      64'(RSP_REN),   64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("r1_wait%0d_ready", i), 64'(HREADYOUT), 64'd0);
            chk($sformatf("r1_wait%0d_ren", i), 64'(RSP_REN), 64'd0);
            chk($sformatf("r1_wait%0d_wen", i), 64'(CMD_WEN), 64'd0);
            tick();
        end
        RSP_REMPTY = 1'b0;
        #1 chk("r1_pop_ren", 64'(RSP_REN),   64'd1);
        chk("r1_pop_ready",  64'(HREADYOUT), 64'd0);
        tick();
        RSP_REMPTY = 1'b1; RSP_RDATA = 32'h12345678;
        #1 chk("r1_data_ready", 64'(HREADYOUT), 64'd1);
        chk("r1_data_hrdata",   64'(HRDATA),    64'h12345678);
        chk("r1_data_ren",      64'(RSP_REN),   64'd0);
        chk("r1_data_wen",      64'(CMD_WEN),   64'd0);
        tick();
        RSP_RDATA = 32'h0BADF00D;
        #1 chk("r1_hold_hrdata", 64'(HRDATA), 64'h12345678);
        tick();

        // back-to-back write, read, write
        addr_ph(2'b10, 1'b1, 3'd2, 25'h10);
        tick();
        HWDATA = 32'h11111111;
        addr_ph(2'b10, 1'b0, 3'd2, 25'h20);
        #1 chk("bb_w1_wen", 64'(CMD_WEN),   64'd1);
        chk("bb_w1_word",   64'(CMD_WDATA), cw(1'b1, 2'b10, 25'h10, 32'h11111111));
        chk("bb_w1_ready",  64'(HREADYOUT), 64'd1);
        chk("bb_w1_hresp",  64'(HRESP),     64'd0);
        tick();
        addr_ph(2'b10, 1'b1, 3'd2, 25'h30);
        #1 chk("bb_r_wen", 64'(CMD_WEN),   64'd1);
        chk("bb_r_word",   64'(CMD_WDATA), cw(1'b0, 2'b10, 25'h20, 32'h0));
        chk("bb_r_ready",  64'(HREADYOUT), 64'd0);
        tick();
        RSP_REMPTY = 1'b0;
        #1 chk("bb_r_ren", 64'(RSP_REN), 64'd1);
        chk("bb_r_nowen",  64'(CMD_WEN), 64'd0);
        chk("bb_r_hresp",  64'(HRESP),   64'd0);
        tick();
        RSP_REMPTY = 1'b1; RSP_RDATA = 32'hA5A5A5A5;
        #1 chk("bb_r_data",  64'(HRDATA),    64'hA5A5A5A5);
        chk("bb_r_dready",   64'(HREADYOUT), 64'd1);
        tick();
        HTRANS = 2'b00; HWDATA = 32'h33333333;
        #1 chk("bb_w2_wen", 64'(CMD_WEN),   64'd1);
        chk("bb_w2_word",   64'(CMD_WDATA), cw(1'b1, 2'b10, 25'h30, 32'h33333333));
        chk("bb_w2_ready",  64'(HREADYOUT), 64'd1);
        chk("bb_w2_hresp",  64'(HRESP),     64'd0);
        tick();
        #1 chk("bb_after_wen", 64'(CMD_WEN), 64'd0);

        // illegal size -> two-cycle ERROR, pending accept in ERR2 is dropped
        addr_ph(2'b10, 1'b1, 3'd3, 25'h40);
        tick();
        HTRANS = 2'b00; HWDATA = 32'h44444444;
        #1 chk("e_1_ready", 64'(HREADYOUT), 64'd0);
        chk("e_1_hresp",    64'(HRESP),     64'd1);
        chk("e_1_wen",      64'(CMD_WEN),   64'd0);
        tick();
        addr_ph(2'b10, 1'b1, 3'd2, 25'h50);
        #1 chk("e_2_ready", 64'(HREADYOUT), 64'd1);
        chk("e_2_hresp",    64'(HRESP),     64'd1);
        chk("e_2_wen",      64'(CMD_WEN),   64'd0);
        tick();
        HTRANS = 2'b00;
        #1 chk("e_cancel_wen", 64'(CMD_WEN), 64'd0);
        chk("e_cancel_hresp",  64'(HRESP),   64'd0);
        chk("e_cancel_ready",  64'(HREADYOUT), 64'd1);
        tick();
        addr_ph(2'b10, 1'b1, 3'd0, 25'h60);
        tick();
        HTRANS = 2'b00; HWDATA = 32'h000000AB;
        #1 chk("e_next_wen", 64'(CMD_WEN),   64'd1);
        chk("e_next_word",   64'(CMD_WDATA), cw(1'b1, 2'b00, 25'h60, 32'h000000AB));
        chk("e_next_hresp",  64'(HRESP),     64'd0);
        tick();

        // asynchronous reset while waiting for a read response
        addr_ph(2'b10, 1'b0, 3'd2, 25'h70);
        tick();
        HTRANS = 2'b00;
        #1 chk("rr_cmd_wen", 64'(CMD_WEN), 64'd1);
        tick();
        #1 chk("rr_wait_ready", 64'(HREADYOUT), 64'd0);
        RSP_REMPTY = 1'b0;
        #1 HRESET = 1'b1;
        #1 chk("rr_rst_ready", 64'(HREADYOUT), 64'd1);
        chk("rr_rst_ren",      64'(RSP_REN),   64'd0);
        chk("rr_rst_hresp",    64'(HRESP),     64'd0);
        chk("rr_rst_hrdata",   64'(HRDATA),    64'd0);
        tick();
        HRESET = 1'b0; RSP_REMPTY = 1'b1;
        addr_ph(2'b10, 1'b1, 3'd2, 25'h80);
        #1 chk("rr_addr_ready", 64'(HREADYOUT), 64'd1);
        tick();
        HTRANS = 2'b00; HWDATA = 32'h5555AAAA;
        #1 chk("rr_w_wen", 64'(CMD_WEN),   64'd1);
        chk("rr_w_ready",  64'(HREADYOUT), 64'd1);
        chk("rr_w_word",   64'(CMD_WDATA), cw(1'b1, 2'b10, 25'h80, 32'h5555AAAA));
        tick();
        #1 chk("rr_after_wen", 64'(CMD_WEN), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
